// File: rtl/store_unit_if.sv
// Request/response and memory-port bundle for store_unit.
// The slave modport is the store unit itself; the master modport is its surroundings.
interface store_unit_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [2:0]        req_funct3;
  logic              done;
  logic              err;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_data, req_funct3, mem_rdata,
    output req_ready, done, err, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_data, req_funct3, mem_rdata,
    input  req_ready, done, err, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/store_unit.sv
// Data-side store path: SW written directly, SB/SH by read-modify-write on a word-wide memory.
// Optional STORE_CNT_EN adds a wrapping count of successfully retired stores (stores_done).
module store_unit #(
  parameter int ADDR_W          = 32,
  parameter int RESET_PC_UNUSED = 0
) (
  input  logic        clk,
  input  logic        rst,
  store_unit_if.slave bus
`ifdef STORE_CNT_EN
  ,
  output logic [31:0] stores_done
`endif
);

  if (RESET_PC_UNUSED != 0) begin : g_bad_param
    $error("store_unit: RESET_PC_UNUSED is reserved and must be 0");
  end

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q;
  logic [1:0]        lane_q;
  logic [15:0]       data_q;
  logic              byte_q;
  logic              ready_q;
  logic              done_q;
  logic              err_q;
  logic              mem_en_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  logic              req_legal;
  logic [ADDR_W-1:0] aligned_addr;
  logic [31:0]       merged_d;

  assign aligned_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    req_legal = 1'b0;
    case (bus.req_funct3)
      F3_SB:   req_legal = 1'b1;
      F3_SH:   req_legal = ~bus.req_addr[0];
      F3_SW:   req_legal = (bus.req_addr[1:0] == 2'b00);
      default: req_legal = 1'b0;
    endcase
  end

  // Replace only the addressed lanes of the word read back during S_WAIT.
  always_comb begin
    merged_d = bus.mem_rdata;
    if (byte_q) begin
      case (lane_q)
        2'd0:    merged_d[7:0]   = data_q[7:0];
        2'd1:    merged_d[15:8]  = data_q[7:0];
        2'd2:    merged_d[23:16] = data_q[7:0];
        default: merged_d[31:24] = data_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged_d[31:16] = data_q;
    end else begin
      merged_d[15:0] = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lane_q      <= 2'b00;
      data_q      <= 16'h0000;
      byte_q      <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            lane_q  <= bus.req_addr[1:0];
            data_q  <= bus.req_data[15:0];
            byte_q  <= (bus.req_funct3 == F3_SB);
            ready_q <= 1'b0;
            if (!req_legal) begin
              state_q <= S_ERR;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (bus.req_funct3 == F3_SW) begin
              state_q     <= S_WRITE;
              mem_en_q    <= 1'b1;
              mem_wr_q    <= 1'b1;
              mem_addr_q  <= aligned_addr;
              mem_wdata_q <= bus.req_data;
            end else begin
              state_q    <= S_READ;
              mem_en_q   <= 1'b1;
              mem_addr_q <= aligned_addr;
            end
          end
        end
        S_READ: begin
          state_q <= S_WAIT;
        end
        // mem_addr_q still holds the aligned address issued for the read.
        S_WAIT: begin
          state_q     <= S_WRITE;
          mem_en_q    <= 1'b1;
          mem_wr_q    <= 1'b1;
          mem_wdata_q <= merged_d;
        end
        S_WRITE: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE, S_ERR: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

`ifdef STORE_CNT_EN
  logic [31:0] stores_done_q;
  logic [31:0] stores_done_d;

  assign stores_done_d = stores_done_q + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      stores_done_q <= 32'h0;
    end else if (state_q == S_DONE) begin
      stores_done_q <= stores_done_d;
    end
  end

  assign stores_done = stores_done_q;
`endif

endmodule
